qam64_det_sched: RTL and testbench
==================================

// Module: qam64_det_sched
// PURPOSE
//  Round-robin scheduler that shares one 64-QAM MIMO LLR detector between two frame sources.
//  Each source owns a frame memory: 36 R words (order R88,R77,R78,R66,...,R17,R18) and 8 y words.
//  Grants one source, reads its memories with a shared address bus, and streams R/y to the detector
//  (R and y start together). Holds the grant until the detector reports done, then acks the source.
// PARAMETERS
//  DW       12   R/y word width (signed, 12b)
//  N_R      36   R words per frame (upper-triangular 8x8)
//  N_Y      8    y words per frame
//  TIMEOUT  255  max WAIT_DONE cycles (only used with QAM64_SCHED_WDOG_EN)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  req        in   2          req[i]=1: source i has a complete frame
//  gnt        out  2          one-hot owner of detector, 0 when idle
//  done_ack   out  2          1-cycle pulse to owning source on frame completion
//  rd_addr    out  6          shared read address to both source memories
//  r_rd_en    out  1          R memory read strobe
//  y_rd_en    out  1          y memory read strobe
//  r_rdata0/1 in   DW         R data from source 0/1, valid 1 cycle after r_rd_en
//  y_rdata0/1 in   DW         y data from source 0/1, valid 1 cycle after y_rd_en
//  det_start  out  1          1-cycle pulse, start of frame to detector
//  det_r      out  DW         R word to detector, 0 when !det_r_vld
//  det_r_vld  out  1          det_r valid
//  det_y      out  DW         y word to detector, 0 when !det_y_vld
//  det_y_vld  out  1          det_y valid
//  det_done   in   1          detector finished LLRs of current frame
//  src_id     out  1          index of current owner (held through WAIT_DONE)
//  busy       out  1          1 in any state other than IDLE
//  err        out  1          watchdog pulse (tied 0 without QAM64_SCHED_WDOG_EN)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer favours source 0, counters 0. Reset mid-frame aborts, no ack.
//  States: IDLE -> FETCH -> DRAIN -> WAIT_DONE -> IDLE.
//  IDLE: if req!=0, choose source (only one requesting: that one; both: the one NOT served last);
//   next cycle enter FETCH with gnt/src_id registered.
//  FETCH: cnt=0..N_R-1, one per cycle; rd_addr=cnt; r_rd_en=1; y_rd_en=1 while cnt<N_Y.
//   det_start=1 in first FETCH cycle only. cnt==N_R-1 -> DRAIN.
//  Data: registered 1-cycle mux by src_id; det_r_vld high N_R consecutive cycles starting the
//   cycle after first FETCH cycle; det_y_vld high its first N_Y cycles. No gaps, no backpressure.
//  DRAIN: 1 cycle, outputs last R word -> WAIT_DONE. rd_addr returns to 0 outside FETCH.
//  WAIT_DONE: on det_done -> IDLE, done_ack[src_id]=1 for 1 cycle, gnt=0, rr pointer updated.
//  det_done outside WAIT_DONE ignored. req changes after grant ignored until IDLE.
//  Min gap between frames: 1 IDLE cycle (det_start spacing >= N_R+3 cycles).
//  Counter width 6b; N_R must be <= 64, N_Y <= N_R.
// CONFIGURATION
//  QAM64_SCHED_WDOG_EN defined: WAIT_DONE counter; TIMEOUT cycles without det_done -> err=1 one cycle,
//   release to IDLE, NO done_ack, rr pointer still advances. Counter cleared on entry to WAIT_DONE.
//  Not defined: no counter, err constant 0, WAIT_DONE waits indefinitely.
// TESTING
//  rst high 2 cycles -> all outputs 0; req=01 at T -> gnt=01 and det_start at T+1, det_r_vld T+2..T+37.
//  Frame check: R/y memories hold idx values -> det_r sequence 0..35, det_y 0..7, zero after vld drops.
//  req=11 from reset -> source 0 first; det_done -> done_ack=01, then source 1 granted, done_ack=10.
//  req=11 held 4 frames -> grant order 0,1,0,1; det_done pulsed during FETCH -> ignored, no ack.
//  rst asserted at FETCH cnt=10 -> next cycle IDLE, vld/gnt 0, no done_ack; new req restarts at cnt 0.
//  WDOG_EN, TIMEOUT=20, det_done never -> err pulse 20 cycles into WAIT_DONE, gnt 0, other source next.

Source files
------------

// File: rtl/qam64_det_sched.sv
// qam64_det_sched: round-robin scheduler sharing one 64-QAM LLR detector between two frame sources.
// Optional WAIT_DONE watchdog enabled by defining QAM64_SCHED_WDOG_EN.
module qam64_det_sched #(
    parameter int DW      = 12,
    parameter int N_R     = 36,
    parameter int N_Y     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic [1:0]    done_ack,
    output logic [5:0]    rd_addr,
    output logic          r_rd_en,
    output logic          y_rd_en,
    input  logic [DW-1:0] r_rdata0,
    input  logic [DW-1:0] r_rdata1,
    input  logic [DW-1:0] y_rdata0,
    input  logic [DW-1:0] y_rdata1,
    output logic          det_start,
    output logic [DW-1:0] det_r,
    output logic          det_r_vld,
    output logic [DW-1:0] det_y,
    output logic          det_y_vld,
    input  logic          det_done,
    output logic          src_id,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_DONE} state_t;
    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic       src_q, src_d, prio_q, prio_d, err_q, err_d, r_vld_q, y_vld_q;
    logic       tmo;
`ifdef QAM64_SCHED_WDOG_EN
    logic [7:0] wd_q;
    assign tmo = state_q == WAIT_DONE && !det_done && wd_q == 8'(TIMEOUT - 1);
    always_ff @(posedge clk)
        wd_q <= (rst || state_q != WAIT_DONE) ? 8'd0 : wd_q + 8'd1;
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        prio_d  = prio_q;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (|req) begin
                // prio_q names the source that wins a tie: the one not served last
                src_d   = (req == 2'b11) ? prio_q : req[1];
                gnt_d   = {src_d, ~src_d};
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(N_R - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = WAIT_DONE;
            WAIT_DONE: if (det_done || tmo) begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                prio_d  = ~src_q;
                ack_d   = det_done ? {src_q, ~src_q} : 2'b00;
                err_d   = tmo;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            src_q   <= 1'b0;
            prio_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            r_vld_q <= 1'b0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            prio_q  <= prio_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            r_vld_q <= r_rd_en;
            y_vld_q <= y_rd_en;
        end
    end
    // Memory data lands one cycle after the strobe, so the delayed strobe qualifies the mux
    assign r_rd_en   = state_q == FETCH;
    assign y_rd_en   = r_rd_en && cnt_q < 6'(N_Y);
    assign rd_addr   = r_rd_en ? cnt_q : 6'd0;
    assign det_start = r_rd_en && cnt_q == 6'd0;
    assign det_r_vld = r_vld_q;
    assign det_y_vld = y_vld_q;
    assign det_r     = r_vld_q ? (src_q ? r_rdata1 : r_rdata0) : '0;
    assign det_y     = y_vld_q ? (src_q ? y_rdata1 : y_rdata0) : '0;
    assign gnt       = gnt_q;
    assign done_ack  = ack_q;
    assign src_id    = src_q;
    assign busy      = state_q != IDLE;
    assign err       = err_q;
endmodule

// File: tb/tb_qam64_det_sched.sv
// tb_qam64_det_sched: randomized scoreboard bench for qam64_det_sched.
// Define QAM64_SCHED_WDOG_EN for both files to also exercise the watchdog (TIMEOUT=20).
module tb_qam64_det_sched;
    localparam int DW = 12;
    logic          clk = 1'b0, rst = 1'b1, det_done = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    gnt, done_ack;
    logic [5:0]    rd_addr;
    logic          r_rd_en, y_rd_en, det_start, det_r_vld, det_y_vld, src_id, busy, err;
    logic [DW-1:0] r_rdata0, r_rdata1, y_rdata0, y_rdata1, det_r, det_y;
    logic [DW-1:0] rm [2][36];
    logic [DW-1:0] ym [2][8];
    int            checks = 0, errors = 0;
    int            prio = 0, since = 99;
    bit            pend_done = 0, mon_en = 1, wdog_win = 0;
    int            exp_owner[$];
    logic [DW-1:0] exp_r[$], exp_y[$];
    logic [1:0]    exp_ack[$];

    qam64_det_sched #(.DW(DW), .N_R(36), .N_Y(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done_ack(done_ack), .rd_addr(rd_addr),
        .r_rd_en(r_rd_en), .y_rd_en(y_rd_en), .r_rdata0(r_rdata0), .r_rdata1(r_rdata1),
        .y_rdata0(y_rdata0), .y_rdata1(y_rdata1), .det_start(det_start), .det_r(det_r),
        .det_r_vld(det_r_vld), .det_y(det_y), .det_y_vld(det_y_vld), .det_done(det_done),
        .src_id(src_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Source frame memories with registered read ports
    always @(posedge clk) begin
        if (r_rd_en) begin
            r_rdata0 <= rm[0][rd_addr];
            r_rdata1 <= rm[1][rd_addr];
        end
        if (y_rd_en) begin
            y_rdata0 <= ym[0][rd_addr[2:0]];
            y_rdata1 <= ym[1][rd_addr[2:0]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        int o;
        if (rst || !mon_en) since = 99;
        else begin
            if (det_start) begin
                since = 0;
                if (exp_owner.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    o = exp_owner.pop_front();
                    chk("gnt", gnt, o ? 2'b10 : 2'b01);
                    chk("src_id", src_id, o);
                end
            end else if (since < 99) since++;
            if (since <= 40) begin
                chk("r_vld_window", det_r_vld, since >= 1 && since <= 36);
                chk("y_vld_window", det_y_vld, since >= 1 && since <= 8);
            end
            if (det_r_vld) begin
                if (exp_r.size() == 0) chk("r_unexpected", det_r_vld, 0);
                else chk("det_r", det_r, exp_r.pop_front());
            end else chk("det_r_zero", det_r, 0);
            if (det_y_vld) begin
                if (exp_y.size() == 0) chk("y_unexpected", det_y_vld, 0);
                else chk("det_y", det_y, exp_y.pop_front());
            end else chk("det_y_zero", det_y, 0);
            if (|done_ack) begin
                if (exp_ack.size() == 0) chk("ack_unexpected", done_ack, 0);
                else chk("done_ack", done_ack, exp_ack.pop_front());
            end
            if (!wdog_win) chk("err_idle", err, 0);
        end
    end

    // mode 0: finish and idle, 1: finish together with the next request, 2: let watchdog expire
    task automatic run_frame(input logic [1:0] rq, input int mode, input bit glitch);
        int owner, n;
        owner = (rq == 2'b11) ? prio : (rq[1] ? 1 : 0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 36; i++) rm[s][i] = DW'($urandom);
            for (int i = 0; i < 8; i++) ym[s][i] = DW'($urandom);
        end
        exp_owner.push_back(owner);
        for (int i = 0; i < 36; i++) exp_r.push_back(rm[owner][i]);
        for (int i = 0; i < 8; i++) exp_y.push_back(ym[owner][i]);
        req = rq;
        if (pend_done) det_done = 1'b1;
        n = 0;
        do begin
            tick();
            det_done = 1'b0;
            n++;
        end while (!det_start && n < 8);
        chk("start_latency", n, pend_done ? 2 : 1);
        chk("start_addr", {rd_addr, r_rd_en, y_rd_en}, {6'd0, 2'b11});
        pend_done = 0;
        req = 2'($urandom);
        for (int k = 1; k <= 37; k++) begin
            det_done = glitch && k == 5;
            tick();
        end
        det_done = 1'b0;
        chk("wait_busy_gnt", {busy, gnt}, {1'b1, owner ? 2'b10 : 2'b01});
`ifdef QAM64_SCHED_WDOG_EN
        if (mode == 2) begin
            req = 2'b00;
            wdog_win = 1;
            n = 0;
            while (!err && n < 40) begin
                tick();
                n++;
            end
            chk("wdog_latency", n, 20);
            chk("wdog_release", {gnt, done_ack, busy}, 0);
            prio = 1 - owner;
            tick();
            wdog_win = 0;
            return;
        end
`endif
        repeat ($urandom_range(0, 4)) tick();
        exp_ack.push_back(owner ? 2'b10 : 2'b01);
        prio = 1 - owner;
        if (mode == 1) pend_done = 1;
        else begin
            det_done = 1'b1;
            req = 2'b00;
            tick();
            det_done = 1'b0;
            chk("ack_now", {done_ack, gnt}, {owner ? 2'b10 : 2'b01, 2'b00});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        tick();
        tick();
        chk("reset_outputs", {gnt, done_ack, rd_addr, r_rd_en, y_rd_en, det_start, det_r, det_r_vld,
                              det_y, det_y_vld, src_id, busy, err}, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        run_frame(2'b11, 1, 0);
        run_frame(2'b11, 1, 0);
        run_frame(2'b11, 1, 0);
        run_frame(2'b11, 0, 1);
        for (int f = 0; f < 14; f++)
            run_frame(2'($urandom_range(1, 3)), (f == 13) ? 0 : int'($urandom_range(0, 1)), 1'($urandom));
        mon_en = 0;
        req = 2'b10;
        tick();
        chk("abort_start", det_start, 1);
        req = 2'b00;
        repeat (10) tick();
        chk("abort_addr", rd_addr, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_idle", {gnt, det_r_vld, det_y_vld, busy, done_ack}, 0);
        prio = 0;
        tick();
        tick();
        chk("abort_no_ack", {done_ack, busy}, 0);
        mon_en = 1;
        run_frame(2'b11, 0, 0);
`ifdef QAM64_SCHED_WDOG_EN
        run_frame(2'b01, 2, 0);
        run_frame(2'b11, 0, 0);
`endif
        repeat (4) tick();
        chk("left_owner", exp_owner.size(), 0);
        chk("left_r", exp_r.size(), 0);
        chk("left_y", exp_y.size(), 0);
        chk("left_ack", exp_ack.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
